cla_adder_16b: RTL and testbench
================================

Name: cla_adder_16b

Overview:
- Registered 16-bit two-level carry-lookahead adder with carry-in.
- Produces a 17-bit result: the 16-bit sum plus the carry-out.
- Drop-in arithmetic leaf for datapaths and approximate-logic benchmark flows. Carries are computed by lookahead, not ripple, so the critical path is logarithmic in width.

Parameters:
- None. Width is fixed at 16 bits and organised as four 4-bit lookahead groups; neither is configurable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in0  input  16  operand A, unsigned
- in1  input  16  operand B, unsigned
- in2  input  1  carry-in
- out0  output  17  registered result {carry_out, sum[15:0]} = in0 + in1 + in2

Behaviour:
- Reset:
  - rst_n low clears out0 to 17'h00000 immediately, with no clock required.
  - Release is synchronous to the next rising clk. The first capture happens on the first rising edge with rst_n high.
- Datapath, combinational stage 1 (bit level):
  - g[i] = in0[i] & in1[i]
  - p[i] = in0[i] ^ in1[i]
- Stage 2 (group level, 4 groups of 4 bits, k = 0..3):
  - Group generate: G_k = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0.
  - Group propagate: P_k = p3·p2·p1·p0.
- Stage 3 (second-level lookahead unit):
  - c0 = in2
  - c4 = G0 | P0·c0
  - c8 = G1 | P1·G0 | P1·P0·c0
  - c12 and c16 follow the same fully expanded pattern.
  - No ripple of group carries is permitted.
- Stage 4 (intra-group carries):
  - Each bit carry is computed by 4-bit lookahead from that group's incoming carry, e.g. c[4k+1] = g[4k] | p[4k]·c[4k].
  - sum[i] = p[i] ^ c[i].
- Register stage:
  - On each rising clk with rst_n high: out0 <= {c16, sum[15:0]}.
  - Latency is exactly 1 cycle. Inputs are sampled at edge N; the result is visible after edge N and holds until edge N+1.
  - The block captures every cycle; there is no enable or handshake.
- Arithmetic:
  - Unsigned, full width, no truncation. Maximum result is 0xFFFF + 0xFFFF + 1 = 0x1FFFF.
  - out0[16] is the unsigned carry-out. No overflow flag is produced.
- Boundary cases:
  - All-propagate case (in0 ^ in1 = 0xFFFF, no generate): the carry-in must pass to c16 through the lookahead P terms, so out0 = 0x0FFFF + in2.
  - Reset asserted mid-stream: out0 goes to 0 asynchronously. The first post-release edge captures the inputs present at that edge.
  - X/Z on inputs is not handled; behaviour is undefined.

Test Plan:
- Reset: hold rst_n=0 with in0=0x1234, in1=0x1111, in2=1 and toggle clk -> out0 stays 0x00000. Release rst_n, give 1 edge -> out0 = 0x02346.
- Max carry: in0=0xFFFF, in1=0xFFFF, in2=1 -> out0 = 0x1FFFF one cycle later. With in2=0 -> 0x1FFFE.
- Full propagate chain: in0=0xFFFF, in1=0x0000, in2=1 -> 0x10000. With in2=0 -> 0x0FFFF.
- Group boundary carries: in0=0x000F, in1=0x0001, in2=0 -> 0x00010. Repeat with in0=0x00FF, 0x0FFF and 0xFFFF (each with in1=0x0001, in2=0) -> 0x00100, 0x01000, 0x10000.
- Pipeline/latency: drive a new vector every cycle (0x0001+0x0001+0, then 0x8000+0x8000+0, then 0xAAAA+0x5555+1) -> out0 = 0x00002, 0x10000, 0x10000 on consecutive cycles, each exactly 1 edge after its inputs.
- Random regression: ≥1,000,000 random {in0, in1, in2} vectors, one per cycle, plus async reset pulses mid-stream -> every out0 equals in0+in1+in2 from the previous edge, and 0 while rst_n is low.

Source files
------------

// File: rtl/cla_adder_16b.sv
// Registered 16-bit adder built from a two-level carry-lookahead tree:
// bit-level g/p, four 4-bit groups, a second-level unit for group carries, one output register.
module cla_adder_16b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic        in2,
    output logic [16:0] out0
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c_bit;
    logic [15:0] sum;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;
    logic [16:0] out0_d;
    logic [16:0] out0_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_group
            localparam int B = 4 * gi;

            assign g[B+3:B] = in0[B+3:B] & in1[B+3:B];
            assign p[B+3:B] = in0[B+3:B] ^ in1[B+3:B];

            assign grp_g[gi] = g[B+3]
                             | (p[B+3] & g[B+2])
                             | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign grp_p[gi] = p[B+3] & p[B+2] & p[B+1] & p[B];

            // Every bit carry comes straight from the group's incoming carry, not from its neighbour.
            assign c_bit[B]   = grp_c[gi];
            assign c_bit[B+1] = g[B] | (p[B] & grp_c[gi]);
            assign c_bit[B+2] = g[B+1]
                              | (p[B+1] & g[B])
                              | (p[B+1] & p[B] & grp_c[gi]);
            assign c_bit[B+3] = g[B+2]
                              | (p[B+2] & g[B+1])
                              | (p[B+2] & p[B+1] & g[B])
                              | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);

            assign sum[B+3:B] = p[B+3:B] ^ c_bit[B+3:B];
        end
    endgenerate

    // Second-level unit: each group carry is a flat sum of products of G/P and the carry-in.
    assign grp_c[0] = in2;
    assign grp_c[1] = grp_g[0]
                    | (grp_p[0] & in2);
    assign grp_c[2] = grp_g[1]
                    | (grp_p[1] & grp_g[0])
                    | (grp_p[1] & grp_p[0] & in2);
    assign grp_c[3] = grp_g[2]
                    | (grp_p[2] & grp_g[1])
                    | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & in2);
    assign grp_c[4] = grp_g[3]
                    | (grp_p[3] & grp_g[2])
                    | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & in2);

    always_comb begin
        out0_d = {grp_c[4], sum};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_q <= 17'h00000;
        end else begin
            out0_q <= out0_d;
        end
    end

    assign out0 = out0_q;

endmodule

// File: tb/tb_cla_adder_16b.sv
// Directed checks of the registered 16-bit CLA adder: reset, carry chains,
// group boundaries, per-cycle latency, async reset mid-stream, plus a short random sweep.
module tb_cla_adder_16b;

    logic        clk;
    logic        rst_n;
    logic [15:0] in0;
    logic [15:0] in1;
    logic        in2;
    logic [16:0] out0;

    int vectors;
    int miscompares;

    cla_adder_16b dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in0  (in0),
        .in1  (in1),
        .in2  (in2),
        .out0 (out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] expected);
        vectors++;
        assert (out0 === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%05h expected=%05h", tag, out0, expected);
        end
    endtask

    // Drive a vector between edges, then check it one edge later.
    task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [16:0] expected);
        @(negedge clk);
        in0 = a;
        in1 = b;
        in2 = c;
        @(posedge clk);
        #1;
        chk(tag, expected);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        in0   = 16'h1234;
        in1   = 16'h1111;
        in2   = 1'b1;

        // Reset held across several edges
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", 17'h00000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release", 17'h02346);

        step("max_carry_ci1",  16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
        step("max_carry_ci0",  16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE);
        step("propagate_ci1",  16'hFFFF, 16'h0000, 1'b1, 17'h10000);
        step("propagate_ci0",  16'hFFFF, 16'h0000, 1'b0, 17'h0FFFF);
        step("propagate_mix",  16'hA5C3, 16'h5A3C, 1'b1, 17'h10000);
        step("grp_boundary_4", 16'h000F, 16'h0001, 1'b0, 17'h00010);
        step("grp_boundary_8", 16'h00FF, 16'h0001, 1'b0, 17'h00100);
        step("grp_boundary_12",16'h0FFF, 16'h0001, 1'b0, 17'h01000);
        step("grp_boundary_16",16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        step("cin_only",       16'h0000, 16'h0000, 1'b1, 17'h00001);
        step("zero",           16'h0000, 16'h0000, 1'b0, 17'h00000);
        step("mixed",          16'h1234, 16'h4321, 1'b0, 17'h05555);

        // Back-to-back vectors; also confirm the value holds until the next edge
        step("pipe_0", 16'h0001, 16'h0001, 1'b0, 17'h00002);
        step("pipe_1", 16'h8000, 16'h8000, 1'b0, 17'h10000);
        @(negedge clk);
        chk("pipe_1_hold", 17'h10000);
        in0 = 16'hAAAA;
        in1 = 16'h5555;
        in2 = 1'b1;
        @(posedge clk);
        #1;
        chk("pipe_2", 17'h10000);

        // Async reset mid-stream: clears without a clock edge
        step("pre_async", 16'h7FFF, 16'h0001, 1'b0, 17'h08000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clear", 17'h00000);
        @(negedge clk);
        in0 = 16'h0F0F;
        in1 = 16'h00F1;
        in2 = 1'b0;
        @(posedge clk);
        #1;
        chk("async_hold", 17'h00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("async_release", 17'h01000);

        // Random sweep with occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic        c;
            logic [16:0] e;
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom);
            e = {1'b0, a} + {1'b0, b} + {16'h0000, c};
            if (i % 500 == 250) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("rand_reset", 17'h00000);
                @(negedge clk);
                rst_n = 1'b1;
            end
            step("random", a, b, c, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
